// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-to-bus bridge. Receives 8N1 command frames ('W' adr[4] dat[4]
// or 'R' adr[4], all MSB-first), runs one 32-bit bus cycle and replies over UART
// ('K' for a write, four data bytes for a read, 'E' for a timed-out cycle).
// Optional feature: define UART_BUS_MASTER_TIMEOUT_EN to abandon bus cycles that
// receive no ack within TIMEOUT cycles; without it the bus wait is unbounded.
module uart_bus_master #(
  parameter logic [15:0] BAUDDIV = 16'd270,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uartRx_i,
  output logic        uartTx_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} parseState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  localparam logic [15:0] BitLast = BAUDDIV - 16'd1;
  localparam logic [15:0] HalfBit = BAUDDIV >> 1;

  logic [1:0]  rxSync_q;
  logic        rxIn;
  rxState_t    rxState_q, rxState_d;
  logic [15:0] rxCnt_q, rxCnt_d;
  logic [2:0]  rxBit_q, rxBit_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic        rxValid_q, rxValid_d;
  logic        frameErr_q, frameErr_d;

  parseState_t pState_q, pState_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  respLeft_q, respLeft_d;

  txState_t    txState_q, txState_d;
  logic [15:0] txCnt_q, txCnt_d;
  logic [2:0]  txBit_q, txBit_d;
  logic [7:0]  txShift_q, txShift_d;
  logic        txLine_q, txLine_d;
  logic        txBitEnd;
  logic        txLoad;
  logic        timedOut;

  assign rxIn = rxSync_q[1];

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [7:0] toCnt_q;

  // Count cycles spent waiting for ack; restarts whenever the parser is outside BUS.
  always_ff @(posedge clk_i) begin
    if (rst_i || pState_q != BUS) toCnt_q <= '0;
    else                          toCnt_q <= toCnt_q + 8'd1;
  end

  assign timedOut = (pState_q == BUS) && (toCnt_q == TIMEOUT - 8'd1);
`else
  assign timedOut = 1'b0;
`endif

  // Receiver: start detection with glitch rejection at mid-start, LSB-first data, stop check.
  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d = '0;
        if (!rxIn) rxState_d = RX_START;
      end
      RX_START: begin
        if (rxCnt_q == HalfBit) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxIn ? RX_IDLE : RX_DATA;
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rxCnt_q == BitLast) begin
          rxCnt_d   = '0;
          rxShift_d = {rxIn, rxShift_q[7:1]};
          rxBit_d   = rxBit_q + 3'd1;
          if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rxCnt_q == BitLast) begin
          rxCnt_d    = '0;
          rxState_d  = RX_IDLE;
          rxValid_d  = rxIn;
          frameErr_d = !rxIn;
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // Synchronizer (idles high) and receiver state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxSync_q   <= 2'b11;
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxSync_q   <= {rxSync_q[0], uartRx_i};
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Command parser, bus handshake and response transmitter; a framing error only
  // aborts a command still being collected, never a bus cycle or a reply in flight.
  always_comb begin
    pState_d   = pState_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    byteCnt_d  = byteCnt_q;
    resp_d     = resp_q;
    respLeft_d = respLeft_q;
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txBit_d    = txBit_q;
    txShift_d  = txShift_q;
    txLine_d   = txLine_q;
    txBitEnd   = (txCnt_q == BitLast);
    txLoad     = 1'b0;
    case (pState_q)
      IDLE: begin
        byteCnt_d = '0;
        if (rxValid_q && rxShift_q == 8'h57) begin
          pState_d = ADDR;
          we_d     = 1'b1;
        end else if (rxValid_q && rxShift_q == 8'h52) begin
          pState_d = ADDR;
          we_d     = 1'b0;
        end
      end
      ADDR: begin
        if (frameErr_q) begin
          pState_d = IDLE;
        end else if (rxValid_q) begin
          adr_d     = {adr_q[23:0], rxShift_q};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) pState_d = we_q ? DATA : BUS;
        end
      end
      DATA: begin
        if (frameErr_q) begin
          pState_d = IDLE;
        end else if (rxValid_q) begin
          dat_d     = {dat_q[23:0], rxShift_q};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) pState_d = BUS;
        end
      end
      BUS: begin
        if (ack_i) begin
          pState_d   = RESP;
          resp_d     = we_q ? 32'h4B00_0000 : dat_i;
          respLeft_d = we_q ? 3'd1 : 3'd4;
        end else if (timedOut) begin
          pState_d   = RESP;
          resp_d     = 32'h4500_0000;
          respLeft_d = 3'd1;
        end
      end
      RESP: begin
        if (txState_q == TX_IDLE && respLeft_q != 3'd0) begin
          txLoad = 1'b1;
        end else if (txState_q == TX_STOP && txBitEnd) begin
          if (respLeft_q != 3'd0) txLoad = 1'b1;
          else                    pState_d = IDLE;
        end
      end
      default: pState_d = IDLE;
    endcase
    if (txLoad) begin
      txState_d  = TX_START;
      txCnt_d    = '0;
      txShift_d  = resp_q[31:24];
      resp_d     = {resp_q[23:0], 8'h00};
      respLeft_d = respLeft_q - 3'd1;
      txLine_d   = 1'b0;
    end else begin
      case (txState_q)
        TX_IDLE: txLine_d = 1'b1;
        TX_START: begin
          if (txBitEnd) begin
            txState_d = TX_DATA;
            txCnt_d   = '0;
            txBit_d   = '0;
            txLine_d  = txShift_q[0];
          end else begin
            txCnt_d = txCnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (txBitEnd) begin
            txCnt_d = '0;
            if (txBit_q == 3'd7) begin
              txState_d = TX_STOP;
              txLine_d  = 1'b1;
            end else begin
              txBit_d   = txBit_q + 3'd1;
              txShift_d = {1'b0, txShift_q[7:1]};
              txLine_d  = txShift_q[1];
            end
          end else begin
            txCnt_d = txCnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (txBitEnd) begin
            txState_d = TX_IDLE;
            txCnt_d   = '0;
            txLine_d  = 1'b1;
          end else begin
            txCnt_d = txCnt_q + 16'd1;
          end
        end
        default: txState_d = TX_IDLE;
      endcase
    end
  end

  // Parser, bus and transmitter state registers; the serial line is registered to stay glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pState_q   <= IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      byteCnt_q  <= '0;
      resp_q     <= '0;
      respLeft_q <= '0;
      txState_q  <= TX_IDLE;
      txCnt_q    <= '0;
      txBit_q    <= '0;
      txShift_q  <= '0;
      txLine_q   <= 1'b1;
    end else begin
      pState_q   <= pState_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      byteCnt_q  <= byteCnt_d;
      resp_q     <= resp_d;
      respLeft_q <= respLeft_d;
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txBit_q    <= txBit_d;
      txShift_q  <= txShift_d;
      txLine_q   <= txLine_d;
    end
  end

  assign uartTx_o = txLine_q;
  assign stb_o    = (pState_q == BUS);
  assign sel_o    = stb_o ? 4'hF : 4'h0;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign busy_o   = (pState_q != IDLE) || (txState_q != TX_IDLE);

endmodule
